// File: rtl/scramble_seed_sequencer_pkg.sv
// Shared opcodes, default widths and FSM state encoding for the scramble seed sequencer.
// Optional feature macro: SCR_SEED_CACHE_EN (row-seed cache, see scramble_seed_sequencer.sv).
package scramble_seed_sequencer_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 16;

  localparam logic [5:0] OP_PAGE_READ  = 6'b000001;
  localparam logic [5:0] OP_SPARE_READ = 6'b000010;
  localparam logic [5:0] OP_ENC_DIS    = 6'b000001;
  localparam logic [5:0] OP_ENC_EN     = 6'b000011;
  localparam logic [5:0] OP_ENC_SEED   = 6'b000000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CFG  = 2'd1,
    S_SEED = 2'd2,
    S_FWD  = 2'd3
  } state_t;

endpackage

// File: rtl/scramble_seed_sequencer_if.sv
// Command channel (payload + valid/ready) used on both sides of the scramble seed sequencer.
// Optional feature macro: SCR_SEED_CACHE_EN (not used in this file).
interface scramble_seed_sequencer_if #(
  parameter int AW = scramble_seed_sequencer_pkg::DEF_ADDR_W,
  parameter int DW = scramble_seed_sequencer_pkg::DEF_DATA_W,
  parameter int LW = scramble_seed_sequencer_pkg::DEF_LEN_W
);
  logic [5:0]    opcode;
  logic [4:0]    target_id;
  logic [4:0]    source_id;
  logic [AW-1:0] address;
  logic [LW-1:0] length;
  logic [DW-1:0] row_address;
  logic          valid;
  logic          ready;

  modport master (
    output opcode, target_id, source_id, address, length, row_address, valid,
    input  ready
  );

  modport slave (
    input  opcode, target_id, source_id, address, length, row_address, valid,
    output ready
  );
endinterface

// File: rtl/scramble_seed_sequencer.sv
// Command-path controller ahead of the scramble encoder: mirrors its enable state and
// inserts a row-seed load before scrambled reads. Optional macro: SCR_SEED_CACHE_EN.
module scramble_seed_sequencer
  import scramble_seed_sequencer_pkg::*;
#(
  parameter int         AddressWidth       = DEF_ADDR_W,
  parameter int         DataWidth          = DEF_DATA_W,
  parameter int         InnerIFLengthWidth = DEF_LEN_W,
  parameter logic [4:0] ScrEncID           = 5'd3
) (
  input  logic                             iClock,
  input  logic                             iReset,
  scramble_seed_sequencer_if.slave         src,
  scramble_seed_sequencer_if.master        dst,
  input  logic                             iScrambleEnable,
  output logic                             oBusy
);

  state_t state_q, state_d;

  logic                          enc_en_q, enc_en_d;
  logic [5:0]                    lat_opcode_q, lat_opcode_d;
  logic [4:0]                    lat_target_q, lat_target_d;
  logic [4:0]                    lat_source_q, lat_source_d;
  logic [AddressWidth-1:0]       lat_address_q, lat_address_d;
  logic [InnerIFLengthWidth-1:0] lat_length_q, lat_length_d;

  logic                          dst_valid_q, dst_valid_d;
  logic [5:0]                    dst_opcode_q, dst_opcode_d;
  logic [4:0]                    dst_target_q, dst_target_d;
  logic [4:0]                    dst_source_q, dst_source_d;
  logic [AddressWidth-1:0]       dst_address_q, dst_address_d;
  logic [InnerIFLengthWidth-1:0] dst_length_q, dst_length_d;

  logic                 cfg_change, src_ready, src_fire, dst_fire;
  logic                 scr_read, seed_hit, need_seed, direct_enc;
  logic [DataWidth-1:0] seed_row;

  // A pending enable change blocks new commands until the encoder has been told.
  assign cfg_change = (state_q == S_IDLE) && (enc_en_q != iScrambleEnable);
  assign src_ready  = (state_q == S_IDLE) && (enc_en_q == iScrambleEnable);
  assign src_fire   = src.valid && src_ready;
  assign dst_fire   = dst_valid_q && dst.ready;
  assign scr_read   = (src.target_id == 5'd0) && enc_en_q &&
                      ((src.opcode == OP_PAGE_READ) || (src.opcode == OP_SPARE_READ));
  assign need_seed  = scr_read && !seed_hit;
  assign direct_enc = (lat_target_q == ScrEncID);
  assign seed_row   = src.row_address;

  assign src.ready       = src_ready;
  assign oBusy           = (state_q != S_IDLE);
  assign dst.valid       = dst_valid_q;
  assign dst.opcode      = dst_opcode_q;
  assign dst.target_id   = dst_target_q;
  assign dst.source_id   = dst_source_q;
  assign dst.address     = dst_address_q;
  assign dst.length      = dst_length_q;
  assign dst.row_address = '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default to the held value first so no path through the case infers a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_change)    state_d = S_CFG;
        else if (src_fire) state_d = need_seed ? S_SEED : S_FWD;
      end
      S_CFG:   if (dst_fire) state_d = S_IDLE;
      S_SEED:  if (dst_fire) state_d = S_FWD;
      S_FWD:   if (dst_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dst_valid_d   = dst_valid_q;
    dst_opcode_d  = dst_opcode_q;
    dst_target_d  = dst_target_q;
    dst_source_d  = dst_source_q;
    dst_address_d = dst_address_q;
    dst_length_d  = dst_length_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_change) begin
          dst_valid_d   = 1'b1;
          dst_opcode_d  = iScrambleEnable ? OP_ENC_EN : OP_ENC_DIS;
          dst_target_d  = ScrEncID;
          dst_source_d  = '0;
          dst_address_d = '0;
          dst_length_d  = '0;
        end else if (src_fire) begin
          dst_valid_d = 1'b1;
          if (need_seed) begin
            dst_opcode_d  = OP_ENC_SEED;
            dst_target_d  = ScrEncID;
            dst_source_d  = '0;
            dst_address_d = AddressWidth'(seed_row);
            dst_length_d  = '0;
          end else begin
            dst_opcode_d  = src.opcode;
            dst_target_d  = src.target_id;
            dst_source_d  = src.source_id;
            dst_address_d = src.address;
            dst_length_d  = src.length;
          end
        end
      end
      S_SEED: begin
        if (dst_fire) begin
          dst_valid_d   = 1'b1;
          dst_opcode_d  = lat_opcode_q;
          dst_target_d  = lat_target_q;
          dst_source_d  = lat_source_q;
          dst_address_d = lat_address_q;
          dst_length_d  = lat_length_q;
        end
      end
      default: if (dst_fire) dst_valid_d = 1'b0;
    endcase
  end

  always_comb begin
    enc_en_d      = enc_en_q;
    lat_opcode_d  = lat_opcode_q;
    lat_target_d  = lat_target_q;
    lat_source_d  = lat_source_q;
    lat_address_d = lat_address_q;
    lat_length_d  = lat_length_q;
    if (src_fire) begin
      lat_opcode_d  = src.opcode;
      lat_target_d  = src.target_id;
      lat_source_d  = src.source_id;
      lat_address_d = src.address;
      lat_length_d  = src.length;
    end
    // The mirror only moves once the encoder has actually taken the command.
    if (dst_fire) begin
      if (state_q == S_CFG) begin
        enc_en_d = (dst_opcode_q == OP_ENC_EN);
      end else if ((state_q == S_FWD) && direct_enc) begin
        if (lat_opcode_q == OP_ENC_DIS)     enc_en_d = 1'b0;
        else if (lat_opcode_q == OP_ENC_EN) enc_en_d = 1'b1;
      end
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      enc_en_q      <= 1'b1;
      lat_opcode_q  <= '0;
      lat_target_q  <= '0;
      lat_source_q  <= '0;
      lat_address_q <= '0;
      lat_length_q  <= '0;
      dst_valid_q   <= 1'b0;
      dst_opcode_q  <= '0;
      dst_target_q  <= '0;
      dst_source_q  <= '0;
      dst_address_q <= '0;
      dst_length_q  <= '0;
    end else begin
      enc_en_q      <= enc_en_d;
      lat_opcode_q  <= lat_opcode_d;
      lat_target_q  <= lat_target_d;
      lat_source_q  <= lat_source_d;
      lat_address_q <= lat_address_d;
      lat_length_q  <= lat_length_d;
      dst_valid_q   <= dst_valid_d;
      dst_opcode_q  <= dst_opcode_d;
      dst_target_q  <= dst_target_d;
      dst_source_q  <= dst_source_d;
      dst_address_q <= dst_address_d;
      dst_length_q  <= dst_length_d;
    end
  end

`ifdef SCR_SEED_CACHE_EN
  logic                 seed_valid_q, seed_valid_d;
  logic [DataWidth-1:0] last_row_q, last_row_d;
  logic [DataWidth-1:0] lat_row_q, lat_row_d;

  assign seed_hit = seed_valid_q && (seed_row == last_row_q);

  always_comb begin
    seed_valid_d = seed_valid_q;
    last_row_d   = last_row_q;
    lat_row_d    = src_fire ? seed_row : lat_row_q;
    if (dst_fire) begin
      case (state_q)
        S_SEED: begin
          seed_valid_d = 1'b1;
          last_row_d   = lat_row_q;
        end
        S_CFG:   seed_valid_d = 1'b0;
        S_FWD:   if (direct_enc) seed_valid_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      seed_valid_q <= 1'b0;
      last_row_q   <= '0;
      lat_row_q    <= '0;
    end else begin
      seed_valid_q <= seed_valid_d;
      last_row_q   <= last_row_d;
      lat_row_q    <= lat_row_d;
    end
  end
`else
  assign seed_hit = 1'b0;
`endif

endmodule
